systolic_job_sequencer: RTL and testbench
=========================================

# systolic_job_sequencer

Command-side initiator for the systolic array controller. It accepts matrix jobs through a valid/ready queue and splits each job's row count into tiles the controller can take. For each tile it drives the controller's start/mode/rows/accumulator-address/clear inputs and waits for its done pulse. It sits between the main instruction decoder and the systolic controller, and reports per-job completion and errors upstream.

## Interface
- TILE_ROWS, 8: maximum rows per tile issued to the controller (1..255).
- FIFO_DEPTH, 4: job queue entries (power of two, ≥2).
- TIMEOUT_CYCLES, 1024: done-wait limit; used only with SEQ_TIMEOUT_EN.
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- job_valid  in  1  job offered.
- job_ready  out  1  queue not full.
- job_mode  in  2  00 MatMul, 01 Conv2D, 10 Accumulate.
- job_rows  in  16  total rows; 0 is illegal.
- job_acc_base  in  8  first accumulator address.
- job_clear  in  1  clear accumulator on the first tile.
- job_done  out  1  one-cycle pulse when a job finishes or aborts.
- job_err  out  1  qualifies job_done; 1 means zero-row job or timeout.
- seq_busy  out  1  job in flight or queue non-empty.
- jobs_completed  out  16  count of job_done pulses; wraps.
- sys_start  out  1  one-cycle tile start.
- sys_mode  out  2  current job mode.
- sys_rows  out  8  current tile rows.
- sys_acc_addr  out  8  current tile base address.
- sys_acc_clear  out  1  clear request for the current tile.
- sys_busy  in  1  controller busy.
- sys_done  in  1  controller one-cycle done pulse.

## Operation
- Job push: job_valid && job_ready writes the job into the FIFO. Push and pop in the same cycle are legal; occupancy is unchanged.
- States:
  - S_IDLE: when the FIFO is non-empty, pop the head into the working registers and go to S_ISSUE. If the popped job has rows == 0, go to S_REPORT with err = 1 instead.
  - S_ISSUE: sys_start = 1 for exactly one cycle. Next state is S_WAIT_DONE.
  - S_WAIT_DONE: on sys_done, subtract the tile size from the remaining rows and add TILE_ROWS to the address (mod 256). If remaining > 0, go to S_ISSUE; else go to S_REPORT.
  - S_REPORT: job_done = 1 and jobs_completed increments. Go to S_IDLE.
- Tile size = min(remaining, TILE_ROWS). The last tile carries the remainder.
- sys_acc_clear = job_clear on the first tile of a job and 0 on later tiles. It is forced to 0 when mode = 10 (Accumulate).
- sys_mode, sys_rows, sys_acc_addr and sys_acc_clear are registered. They stay stable from S_ISSUE until sys_done, because the controller's write address follows sys_acc_addr combinationally for the whole operation.
- sys_done outside S_WAIT_DONE is ignored. sys_busy is status only and does not drive transitions.

## Timing
- Reset value of all outputs is 0, except job_ready = 1. On reset the FIFO empties and the state goes to S_IDLE.
- Reset mid-job: sys_start is low from the reset edge onward. The in-flight job is discarded and no job_done is issued for it.
- Latency with an idle sequencer and empty FIFO: job accepted at edge N, pop at N+1, sys_start high during cycle N+2.
- Next tile: sys_start is high one cycle after the sys_done cycle.
- job_done: high in the cycle after the final sys_done.
- Back-to-back jobs: the next pop happens in the cycle after S_REPORT.
- job_ready = 0 exactly when the FIFO holds FIFO_DEPTH entries.

## Configuration
- SEQ_TIMEOUT_EN
  - Defined: a counter runs in S_WAIT_DONE and resets on each S_ISSUE. On reaching TIMEOUT_CYCLES without sys_done, the job aborts: remaining tiles are dropped, the state goes to S_REPORT with job_err = 1, and a later stray sys_done is ignored.
  - Undefined: no counter; the sequencer waits indefinitely, and job_err is raised only for zero-row jobs.

## Structure
- Package tpu_seq_pkg:
  - sys_mode_t enum (MatMul, Conv2D, Accumulate).
  - seq_job_t struct (mode, rows, acc_base, clear).
  - seq_state_t enum.
  - Default TILE_ROWS constant.
- Sub-module systolic_job_fifo: synchronous FIFO of seq_job_t with FIFO_DEPTH entries and full/empty flags. Read data is registered and valid the cycle after push.

## Test plan
- Job rows = 20, base 0x10, clear = 1, mode 00 → tiles issued as (8 rows, 0x10, clear 1), then (8, 0x18, 0), then (4, 0x20, 0); one job_done with err = 0; jobs_completed = 1.
- Job rows = 0 → no sys_start; job_done with err = 1 two cycles after accept; jobs_completed increments.
- Address wrap: base 0xFC, rows = 16 → tiles at 0xFC then 0x04.
- Accumulate mode, clear = 1, rows = 8 → single tile issued with sys_acc_clear = 0.
- sys_done withheld, five jobs pushed → first job pops and issues; the queue then fills with jobs 2–5, and job_ready drops after the fifth accept. Releasing sys_done drains all jobs in order.
- SEQ_TIMEOUT_EN with TIMEOUT_CYCLES = 16, sys_done never asserted → job_done with err = 1 after 16 wait cycles. Separately, rst asserted mid-tile → all outputs return to reset values and no job_done is issued.

Source files
------------

// File: rtl/tpu_seq_pkg.sv
// Shared types for the systolic job sequencer.
// Job record, controller mode encoding, sequencer FSM states.
package tpu_seq_pkg;

  typedef enum logic [1:0] {
    MODE_MATMUL = 2'b00,
    MODE_CONV2D = 2'b01,
    MODE_ACCUM  = 2'b10
  } sys_mode_t;

  typedef struct packed {
    sys_mode_t   mode;
    logic [15:0] rows;
    logic [7:0]  acc_base;
    logic        clear;
  } seq_job_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_REPORT
  } seq_state_t;

  localparam int DEF_TILE_ROWS = 8;

  function automatic logic [7:0] tile_size(
    input logic [15:0] rem,
    input logic [7:0]  tile
  );
    return (rem < {8'd0, tile}) ? rem[7:0] : tile;
  endfunction

endpackage

// File: rtl/systolic_job_fifo.sv
// Job queue for the sequencer: synchronous FIFO of seq_job_t.
// Head entry is read straight from storage flops.
module systolic_job_fifo
  import tpu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  seq_job_t wdata_i,
  input  logic     pop_i,
  output seq_job_t rdata_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(DEPTH);

  seq_job_t      mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/systolic_job_sequencer.sv
// Splits queued matrix jobs into row tiles for the systolic controller.
// Optional done-wait watchdog enabled by SEQ_TIMEOUT_EN.
module systolic_job_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int TILE_ROWS      = DEF_TILE_ROWS,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [1:0]  job_mode,
  input  logic [15:0] job_rows,
  input  logic [7:0]  job_acc_base,
  input  logic        job_clear,
  output logic        job_done,
  output logic        job_err,
  output logic        seq_busy,
  output logic [15:0] jobs_completed,
  output logic        sys_start,
  output logic [1:0]  sys_mode,
  output logic [7:0]  sys_rows,
  output logic [7:0]  sys_acc_addr,
  output logic        sys_acc_clear,
  input  logic        sys_busy,
  input  logic        sys_done
);

  localparam logic [7:0] TILE = 8'(TILE_ROWS);

  seq_state_t  state_q, state_d;
  seq_job_t    wjob, head;
  logic        full, empty, pop;
  logic [15:0] rem_q, rem_d, rem_nx;
  logic [15:0] done_cnt_q;
  logic        err_q, err_d;
  sys_mode_t   mode_q, mode_d;
  logic [7:0]  rows_q, rows_d;
  logic [7:0]  addr_q, addr_d;
  logic        clr_q, clr_d;
  logic        tmo_hit;

  always_comb begin
    wjob          = '0;
    wjob.mode     = sys_mode_t'(job_mode);
    wjob.rows     = job_rows;
    wjob.acc_base = job_acc_base;
    wjob.clear    = job_clear;
  end

  systolic_job_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (job_valid),
    .wdata_i (wjob),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || state_q == S_ISSUE) tmo_q <= '0;
    else if (state_q == S_WAIT_DONE) tmo_q <= tmo_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    err_d   = err_q;
    mode_d  = mode_q;
    rows_d  = rows_q;
    addr_d  = addr_q;
    clr_d   = clr_q;
    pop     = 1'b0;
    rem_nx  = rem_q - {8'd0, rows_q};
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          err_d = (head.rows == '0);
          if (head.rows == '0) begin
            state_d = S_REPORT;
          end else begin
            state_d = S_ISSUE;
            rem_d   = head.rows;
            mode_d  = head.mode;
            rows_d  = tile_size(head.rows, TILE);
            addr_d  = head.acc_base;
            clr_d   = head.clear && (head.mode != MODE_ACCUM);
          end
        end
      end
      S_ISSUE: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (sys_done) begin
          rem_d = rem_nx;
          if (rem_nx != '0) begin
            state_d = S_ISSUE;
            rows_d  = tile_size(rem_nx, TILE);
            addr_d  = addr_q + TILE;
            clr_d   = 1'b0;
          end else begin
            state_d = S_REPORT;
          end
        end else if (tmo_hit) begin
          // Abort: drop remaining tiles, report as error
          err_d   = 1'b1;
          state_d = S_REPORT;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      err_q      <= 1'b0;
      mode_q     <= MODE_MATMUL;
      rows_q     <= '0;
      addr_q     <= '0;
      clr_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
      rows_q  <= rows_d;
      addr_q  <= addr_d;
      clr_q   <= clr_d;
      if (state_q == S_REPORT) done_cnt_q <= done_cnt_q + 1'b1;
    end
  end

  assign job_ready      = !full;
  assign job_done       = (state_q == S_REPORT);
  assign job_err        = job_done && err_q;
  assign seq_busy       = (state_q != S_IDLE) || !empty;
  assign jobs_completed = done_cnt_q;
  assign sys_start      = (state_q == S_ISSUE);
  assign sys_mode       = mode_q;
  assign sys_rows       = rows_q;
  assign sys_acc_addr   = addr_q;
  assign sys_acc_clear  = clr_q;

  logic unused_ok;
  assign unused_ok = sys_busy;

endmodule

// File: tb/tb_systolic_job_sequencer.sv
// Directed bench for systolic_job_sequencer with a simple controller model.
// Timeout scenario runs when SEQ_TIMEOUT_EN is defined.
module tb_systolic_job_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [1:0]  job_mode;
  logic [15:0] job_rows;
  logic [7:0]  job_acc_base;
  logic        job_clear;
  logic        job_done;
  logic        job_err;
  logic        seq_busy;
  logic [15:0] jobs_completed;
  logic        sys_start;
  logic [1:0]  sys_mode;
  logic [7:0]  sys_rows;
  logic [7:0]  sys_acc_addr;
  logic        sys_acc_clear;
  logic        sys_busy;
  logic        sys_done;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    int rows;
    int addr;
    int clr;
    int mode;
  } tile_t;

  tile_t tiles[$];
  int    dones[$];
  bit    waiting = 0;
  bit    hold    = 0;
  int    rcnt    = 0;

  always #5 clk = ~clk;

  systolic_job_sequencer #(
    .TILE_ROWS      (8),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_mode       (job_mode),
    .job_rows       (job_rows),
    .job_acc_base   (job_acc_base),
    .job_clear      (job_clear),
    .job_done       (job_done),
    .job_err        (job_err),
    .seq_busy       (seq_busy),
    .jobs_completed (jobs_completed),
    .sys_start      (sys_start),
    .sys_mode       (sys_mode),
    .sys_rows       (sys_rows),
    .sys_acc_addr   (sys_acc_addr),
    .sys_acc_clear  (sys_acc_clear),
    .sys_busy       (sys_busy),
    .sys_done       (sys_done)
  );

  assign sys_busy = waiting;

  always @(negedge clk) begin
    if (sys_start) begin
      tiles.push_back('{int'(sys_rows), int'(sys_acc_addr),
                       int'(sys_acc_clear), int'(sys_mode)});
      waiting = 1;
    end
    if (job_done) dones.push_back(int'(job_err));
  end

  // Controller model: done pulse three cycles after each start
  initial begin
    sys_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      sys_done = 1'b0;
      if (waiting && !hold) begin
        if (rcnt == 2) begin
          sys_done = 1'b1;
          waiting  = 0;
          rcnt     = 0;
        end else begin
          rcnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] m, input logic [15:0] r,
                      input logic [7:0] b, input logic c);
    job_valid    = 1'b1;
    job_mode     = m;
    job_rows     = r;
    job_acc_base = b;
    job_clear    = c;
    for (int k = 0; k < 50 && !job_ready; k++) tick();
    if (!job_ready) begin
      total++;
      $display("FAIL push_timeout: job_ready=%0b want 1", job_ready);
    end
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_dones(input int n);
    for (int k = 0; k < 500 && dones.size() < n; k++) tick();
    total++;
    if (dones.size() != n)
      $display("FAIL done_count: got %0d want %0d", dones.size(), n);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    job_valid = 1'b0;
    job_mode = 2'b00;
    job_rows = '0;
    job_acc_base = '0;
    job_clear = 1'b0;
    tick();
    tick();
    total++;
    if ({job_ready, job_done, job_err, seq_busy, sys_start} !== 5'b10000)
      $display("FAIL reset_flags: got %b want 10000",
               {job_ready, job_done, job_err, seq_busy, sys_start});
    else pass_cnt++;
    total++;
    if ({jobs_completed, sys_rows, sys_acc_addr, sys_mode, sys_acc_clear} !== 35'd0)
      $display("FAIL reset_values: got %h want 0",
               {jobs_completed, sys_rows, sys_acc_addr, sys_mode, sys_acc_clear});
    else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_multi_tile();
    int er[3] = '{8, 8, 4};
    int ea[3] = '{8'h10, 8'h18, 8'h20};
    int ec[3] = '{1, 0, 0};
    tiles.delete();
    dones.delete();
    push(2'b00, 16'd20, 8'h10, 1'b1);
    total++;
    if (sys_start !== 1'b0)
      $display("FAIL latency_early: sys_start=%0b want 0", sys_start);
    else pass_cnt++;
    tick();
    total++;
    if ({sys_start, sys_rows} !== {1'b1, 8'd8})
      $display("FAIL latency_start: got %b/%0d want 1/8", sys_start, sys_rows);
    else pass_cnt++;
    wait_dones(1);
    total++;
    if (tiles.size() != 3)
      $display("FAIL multi_ntiles: got %0d want 3", tiles.size());
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= tiles.size())
        $display("FAIL multi_tile%0d: missing", i);
      else if (tiles[i].rows != er[i] || tiles[i].addr != ea[i] ||
               tiles[i].clr != ec[i] || tiles[i].mode != 0)
        $display("FAIL multi_tile%0d: got %0d/%h/%0d want %0d/%h/%0d", i,
                 tiles[i].rows, tiles[i].addr, tiles[i].clr, er[i], ea[i], ec[i]);
      else pass_cnt++;
    end
    total++;
    if (dones.size() != 1 || dones[0] != 0 || jobs_completed !== 16'd1)
      $display("FAIL multi_done: err=%0d cnt=%0d want 0/1",
               dones.size() ? dones[0] : -1, jobs_completed);
    else pass_cnt++;
  endtask

  task automatic test_zero_rows();
    tiles.delete();
    dones.delete();
    push(2'b00, 16'd0, 8'h33, 1'b1);
    total++;
    if (job_done !== 1'b0)
      $display("FAIL zero_early: job_done=%0b want 0", job_done);
    else pass_cnt++;
    tick();
    total++;
    if ({job_done, job_err, sys_start} !== 3'b110)
      $display("FAIL zero_report: got %b want 110", {job_done, job_err, sys_start});
    else pass_cnt++;
    tick();
    total++;
    if (job_done !== 1'b0 || jobs_completed !== 16'd2 || tiles.size() != 0)
      $display("FAIL zero_after: done=%0b cnt=%0d tiles=%0d want 0/2/0",
               job_done, jobs_completed, tiles.size());
    else pass_cnt++;
  endtask

  task automatic test_addr_wrap();
    tiles.delete();
    dones.delete();
    push(2'b01, 16'd16, 8'hFC, 1'b0);
    wait_dones(1);
    total++;
    if (tiles.size() != 2)
      $display("FAIL wrap_ntiles: got %0d want 2", tiles.size());
    else if (tiles[0].addr != 8'hFC || tiles[1].addr != 8'h04 ||
             tiles[0].rows != 8 || tiles[1].rows != 8 || tiles[1].mode != 1)
      $display("FAIL wrap_addr: got %h,%h want fc,04", tiles[0].addr, tiles[1].addr);
    else pass_cnt++;
  endtask

  task automatic test_accumulate();
    tiles.delete();
    dones.delete();
    push(2'b10, 16'd8, 8'h40, 1'b1);
    wait_dones(1);
    total++;
    if (tiles.size() != 1)
      $display("FAIL accum_ntiles: got %0d want 1", tiles.size());
    else if (tiles[0].clr != 0 || tiles[0].mode != 2 || tiles[0].rows != 8)
      $display("FAIL accum_clear: got clr=%0d mode=%0d want 0/2",
               tiles[0].clr, tiles[0].mode);
    else pass_cnt++;
    total++;
    if (jobs_completed !== 16'd4)
      $display("FAIL accum_count: got %0d want 4", jobs_completed);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int r[5]  = '{3, 5, 9, 1, 2};
    int er[6] = '{3, 5, 8, 1, 1, 2};
    int ea[6] = '{8'h00, 8'h20, 8'h40, 8'h48, 8'h60, 8'h80};
    int ec[6] = '{1, 1, 1, 0, 1, 1};
    tiles.delete();
    dones.delete();
    hold = 1;
    for (int i = 0; i < 5; i++)
      push(2'b01, 16'(r[i]), 8'(i * 32), 1'b1);
    total++;
    if (job_ready !== 1'b0 || seq_busy !== 1'b1 || tiles.size() != 1)
      $display("FAIL b2b_full: ready=%0b busy=%0b tiles=%0d want 0/1/1",
               job_ready, seq_busy, tiles.size());
    else pass_cnt++;
    hold = 0;
    wait_dones(5);
    total++;
    if (tiles.size() != 6)
      $display("FAIL b2b_ntiles: got %0d want 6", tiles.size());
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (i >= tiles.size())
        $display("FAIL b2b_tile%0d: missing", i);
      else if (tiles[i].rows != er[i] || tiles[i].addr != ea[i] ||
               tiles[i].clr != ec[i])
        $display("FAIL b2b_tile%0d: got %0d/%h/%0d want %0d/%h/%0d", i,
                 tiles[i].rows, tiles[i].addr, tiles[i].clr, er[i], ea[i], ec[i]);
      else pass_cnt++;
    end
    total++;
    if (jobs_completed !== 16'd9 || job_ready !== 1'b1 || dones.sum() != 0)
      $display("FAIL b2b_end: cnt=%0d ready=%0b errs=%0d want 9/1/0",
               jobs_completed, job_ready, dones.sum());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    tiles.delete();
    dones.delete();
    hold = 1;
    push(2'b00, 16'd20, 8'h10, 1'b1);
    tick();
    tick();
    tick();
    total++;
    if (tiles.size() != 1)
      $display("FAIL rmid_issue: tiles=%0d want 1", tiles.size());
    else pass_cnt++;
    rst = 1'b1;
    tick();
    total++;
    if ({sys_start, job_done, seq_busy, job_ready} !== 4'b0001 ||
        {jobs_completed, sys_rows, sys_acc_addr, sys_acc_clear} !== 33'd0)
      $display("FAIL rmid_outputs: got %b/%h want 0001/0",
               {sys_start, job_done, seq_busy, job_ready},
               {jobs_completed, sys_rows, sys_acc_addr, sys_acc_clear});
    else pass_cnt++;
    rst = 1'b0;
    hold = 0;
    for (int k = 0; k < 8; k++) tick();
    total++;
    if (dones.size() != 0 || seq_busy !== 1'b0 || tiles.size() != 1)
      $display("FAIL rmid_nodone: dones=%0d busy=%0b tiles=%0d want 0/0/1",
               dones.size(), seq_busy, tiles.size());
    else pass_cnt++;
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    tiles.delete();
    dones.delete();
    hold = 1;
    push(2'b00, 16'd20, 8'h00, 1'b0);
    tick();
    total++;
    if (sys_start !== 1'b1)
      $display("FAIL tmo_start: sys_start=%0b want 1", sys_start);
    else pass_cnt++;
    for (int k = 0; k < 16; k++) tick();
    total++;
    if (job_done !== 1'b0)
      $display("FAIL tmo_early: job_done=%0b want 0", job_done);
    else pass_cnt++;
    tick();
    total++;
    if ({job_done, job_err} !== 2'b11)
      $display("FAIL tmo_report: got %b want 11", {job_done, job_err});
    else pass_cnt++;
    hold = 0;
    for (int k = 0; k < 8; k++) tick();
    total++;
    if (dones.size() != 1 || tiles.size() != 1 || jobs_completed !== 16'd1)
      $display("FAIL tmo_stray: dones=%0d tiles=%0d cnt=%0d want 1/1/1",
               dones.size(), tiles.size(), jobs_completed);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_multi_tile();
    test_zero_rows();
    test_addr_wrap();
    test_accumulate();
    test_back_to_back();
    test_reset_mid();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
